// File: rtl/ch1_sweep.sv
// Channel 1 frequency sweep engine: periodically recomputes the 11-bit
// channel frequency from the NR10 configuration and writes it back to the ch1 registers.
module ch1_sweep (
   input  logic        dyfa_1mhz,
   input  logic        napu_reset,
   input  logic        sweep_tick,
   input  logic        ch1_restart,
   input  logic [6:0]  nff10,
   input  logic [10:0] freq_in,
   output logic [10:0] acc_d,
   output logic        acc_load,
   output logic        ch1_off,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      CHECK = 2'd2
   } sweep_state_t;

   sweep_state_t state;

   logic [10:0] shadow;
   logic [3:0]  timer;
   logic        en;
   logic        neg_used;

   logic [2:0]  shift;
   logic [2:0]  period;
   logic        neg;
   logic [3:0]  reload;
   logic [11:0] delta;
   logic [11:0] sum;
   logic        overflow;

   // NR10 is delivered inverted; decode it back to true polarity.
   assign shift  = ~nff10[2:0];
   assign neg    = ~nff10[3];
   assign period = ~nff10[6:4];
   assign reload = (period == 3'd0) ? 4'd8 : {1'b0, period};

   // Subtraction can never borrow: the delta is at most the shadow itself.
   assign delta    = {1'b0, shadow >> shift};
   assign sum      = neg ? ({1'b0, shadow} - delta) : ({1'b0, shadow} + delta);
   assign overflow = sum[11];

   assign busy = (state != IDLE);

   // Write-back: acc_load qualifies acc_d for exactly one cycle. There is no
   // ready; the register block must accept the value in the cycle it is strobed.
   always_ff @(posedge dyfa_1mhz or negedge napu_reset) begin
      if (!napu_reset) begin
         state    <= IDLE;
         shadow   <= 11'd0;
         timer    <= 4'd0;
         en       <= 1'b0;
         neg_used <= 1'b0;
         acc_d    <= 11'd0;
         acc_load <= 1'b0;
         ch1_off  <= 1'b0;
      end else begin
         acc_load <= 1'b0;
         if (ch1_restart) begin
            shadow   <= freq_in;
            timer    <= reload;
            en       <= (period != 3'd0) || (shift != 3'd0);
            neg_used <= 1'b0;
            ch1_off  <= 1'b0;
            state    <= (shift != 3'd0) ? CHECK : IDLE;
         end else begin
            if (sweep_tick) begin
               if (timer > 4'd1) begin
                  timer <= timer - 4'd1;
               end else begin
                  timer <= reload;
                  // A request arriving while a calculation is in flight is dropped.
                  if (en && (period != 3'd0) && (state == IDLE))
                     state <= CALC;
               end
            end

            case (state)
               CALC: begin
                  if (overflow) begin
                     ch1_off <= 1'b1;
                  end else if (shift != 3'd0) begin
                     shadow   <= sum[10:0];
                     acc_d    <= sum[10:0];
                     acc_load <= 1'b1;
                  end
                  neg_used <= neg_used | neg;
                  state    <= CHECK;
               end
               CHECK: begin
                  if (overflow)
                     ch1_off <= 1'b1;
                  neg_used <= neg_used | neg;
                  state    <= IDLE;
               end
               default: ;
            endcase

            // Leaving negate mode after a negate calculation has been used kills the channel.
            if (neg_used && !neg)
               ch1_off <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ch1_sweep.sv
// Bench for ch1_sweep: directed scenarios plus randomized traffic, all
// compared against a cycle-level behavioural model of the sweep rules.
module tb_ch1_sweep;

   logic        dyfa_1mhz;
   logic        napu_reset;
   logic        sweep_tick;
   logic        ch1_restart;
   logic [6:0]  nff10;
   logic [10:0] freq_in;
   logic [10:0] acc_d;
   logic        acc_load;
   logic        ch1_off;
   logic        busy;

   int n_checks;
   int n_pass;

   // Behavioural model state.
   int m_shadow, m_timer, m_accd, m_steps;
   bit m_en, m_negused, m_off, m_load;

   logic [10:0] exp_q[$];
   logic [10:0] got_loads[$];

   ch1_sweep dut (
      .dyfa_1mhz   (dyfa_1mhz),
      .napu_reset  (napu_reset),
      .sweep_tick  (sweep_tick),
      .ch1_restart (ch1_restart),
      .nff10       (nff10),
      .freq_in     (freq_in),
      .acc_d       (acc_d),
      .acc_load    (acc_load),
      .ch1_off     (ch1_off),
      .busy        (busy)
   );

   // Clock and reset defaults.
   initial dyfa_1mhz = 1'b0;
   always #5 dyfa_1mhz = ~dyfa_1mhz;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [6:0] cfg(input int sh, input int ng, input int per);
      logic [6:0] v;
      v = {per[2:0], ng[0], sh[2:0]};
      return ~v;
   endfunction

   task automatic model_reset();
      m_shadow = 0; m_timer = 0; m_accd = 0; m_steps = 0;
      m_en = 0; m_negused = 0; m_off = 0; m_load = 0;
   endtask

   // m_steps counts the remaining busy cycles: 2 = calculation pending, 1 = check pending.
   task automatic model_step(input bit trig, input bit tick, input logic [6:0] c, input logic [10:0] fin);
      logic [2:0] s3, p3;
      int sh, per, rl, nxt;
      bit ng, ovf, quirk, start;
      s3 = ~c[2:0];
      p3 = ~c[6:4];
      ng = ~c[3];
      sh = s3;
      per = p3;
      rl = (per == 0) ? 8 : per;
      m_load = 0;
      if (trig) begin
         m_shadow = fin; m_timer = rl; m_en = (per != 0) || (sh != 0);
         m_negused = 0; m_off = 0; m_steps = (sh != 0) ? 1 : 0;
         return;
      end
      nxt = ng ? m_shadow - (m_shadow >> sh) : m_shadow + (m_shadow >> sh);
      ovf = nxt > 2047;
      quirk = m_negused && !ng;
      start = 0;
      if (tick) begin
         if (m_timer > 1) m_timer--;
         else begin
            m_timer = rl;
            start = m_en && (per != 0) && (m_steps == 0);
         end
      end
      if (m_steps == 2) begin
         if (ovf) m_off = 1;
         else if (sh != 0) begin m_shadow = nxt; m_accd = nxt; m_load = 1; end
         m_negused = m_negused | ng;
         m_steps = 1;
      end else if (m_steps == 1) begin
         if (ovf) m_off = 1;
         m_negused = m_negused | ng;
         m_steps = 0;
      end
      if (quirk) m_off = 1;
      if (start) m_steps = 2;
   endtask

   task automatic compare_outputs();
      check("acc_d", acc_d, m_accd);
      check("acc_load", acc_load, m_load);
      check("ch1_off", ch1_off, m_off);
      check("busy", busy, m_steps != 0);
      if (m_load) exp_q.push_back(m_accd[10:0]);
      if (acc_load) begin
         got_loads.push_back(acc_d);
         if (exp_q.size() == 0) check("unexpected_load", 1, 0);
         else check("load_value", acc_d, exp_q.pop_front());
      end
   endtask

   // Driver: one clock with the given strobes, model update, then compare.
   task automatic cycle(input bit trig, input bit tick);
      ch1_restart = trig;
      sweep_tick  = tick;
      @(posedge dyfa_1mhz);
      model_step(trig, tick, nff10, freq_in);
      #1;
      ch1_restart = 1'b0;
      sweep_tick  = 1'b0;
      compare_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0);
   endtask

   initial begin
      n_checks = 0;
      n_pass = 0;
      napu_reset = 1'b0;
      sweep_tick = 1'b0;
      ch1_restart = 1'b0;
      nff10 = 7'h7f;
      freq_in = 11'd0;
      model_reset();
      #1;
      check("rst_acc_d", acc_d, 0);
      check("rst_acc_load", acc_load, 0);
      check("rst_off", ch1_off, 0);
      check("rst_busy", busy, 0);
      repeat (2) @(posedge dyfa_1mhz);
      #1 napu_reset = 1'b1;

      // Add, shift 1, period 1: write-back then overflow in the check.
      nff10 = cfg(1, 0, 1); freq_in = 11'h400;
      cycle(1, 0);
      check("t1_trig_off", ch1_off, 0);
      idle(1);
      check("t1_check_off", ch1_off, 0);
      cycle(0, 1);
      idle(1);
      check("t1_load", acc_load, 1);
      check("t1_acc_d", acc_d, 11'h600);
      idle(1);
      check("t1_off", ch1_off, 1);
      check("t1_load_drop", acc_load, 0);
      idle(2);

      // Overflow detected by the trigger-time check.
      got_loads.delete();
      nff10 = cfg(1, 0, 0); freq_in = 11'h700;
      cycle(1, 0);
      idle(1);
      check("t2_off", ch1_off, 1);
      idle(3);
      check("t2_no_load", got_loads.size(), 0);

      // Negate, shift 2, period 2.
      got_loads.delete();
      nff10 = cfg(2, 1, 2); freq_in = 11'h100;
      cycle(1, 0);
      idle(1);
      for (int t = 0; t < 4; t++) begin
         cycle(0, 1);
         idle(2);
      end
      check("t3_nloads", got_loads.size(), 2);
      if (got_loads.size() == 2) begin
         check("t3_load0", got_loads[0], 11'h0c0);
         check("t3_load1", got_loads[1], 11'h090);
      end
      check("t3_off", ch1_off, 0);

      // Period 0: no calculations, timer reloads to 8.
      got_loads.delete();
      nff10 = cfg(3, 0, 0); freq_in = 11'h200;
      cycle(1, 0);
      idle(1);
      for (int t = 0; t < 16; t++) begin
         cycle(0, 1);
         idle(1);
      end
      check("t4_timer16", dut.timer, 8);
      for (int t = 0; t < 4; t++) begin
         cycle(0, 1);
         idle(1);
      end
      check("t4_timer20", dut.timer, 4);
      check("t4_no_load", got_loads.size(), 0);

      // Negate quirk: leaving negate after a negate check disables the channel.
      nff10 = cfg(1, 1, 0); freq_in = 11'h100;
      cycle(1, 0);
      idle(1);
      check("t5_pre_off", ch1_off, 0);
      nff10 = cfg(1, 0, 0);
      idle(1);
      check("t5_quirk_off", ch1_off, 1);
      nff10 = cfg(0, 1, 0);
      cycle(1, 0);
      idle(1);
      nff10 = cfg(0, 0, 0);
      idle(3);
      check("t5_no_quirk", ch1_off, 0);

      // Reset while a calculation is in flight.
      nff10 = cfg(1, 0, 1); freq_in = 11'h100;
      cycle(1, 0);
      idle(2);
      cycle(0, 1);
      check("t6_busy", busy, 1);
      napu_reset = 1'b0;
      model_reset();
      exp_q.delete();
      #1;
      check("t6_acc_d", acc_d, 0);
      check("t6_acc_load", acc_load, 0);
      check("t6_off", ch1_off, 0);
      check("t6_busy0", busy, 0);
      @(posedge dyfa_1mhz);
      #1;
      check("t6_held_load", acc_load, 0);
      napu_reset = 1'b1;
      cycle(1, 0);
      idle(1);
      cycle(0, 1);
      idle(1);
      check("t6_after_load", acc_load, 1);
      check("t6_after_acc_d", acc_d, 11'h180);
      idle(2);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 19) == 0) nff10 = 7'($urandom_range(0, 127));
         if ($urandom_range(0, 7) == 0) freq_in = 11'($urandom_range(0, 2047));
         cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
      end
      idle(3);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
